// File: rtl/am2940_dma_sequencer_pkg.sv
// Shared definitions for the am2940 DMA sequencer: am2940 instruction codes,
// FSM state encoding and the Moore output decode for each state.
package am2940_dma_sequencer_pkg;

    typedef enum logic [2:0] {
        I_WR_CR   = 3'd0,
        I_RD_CR   = 3'd1,
        I_RD_WC   = 3'd2,
        I_RD_AC   = 3'd3,
        I_REINIT  = 3'd4,
        I_LD_ADDR = 3'd5,
        I_LD_WC   = 3'd6,
        I_EN_CNT  = 3'd7
    } am2940_instr_e;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LD_CR = 4'd1,
        S_LD_AD = 4'd2,
        S_LD_WC = 4'd3,
        S_ARM   = 4'd4,
        S_REQ   = 4'd5,
        S_STEP  = 4'd6,
        S_CHECK = 4'd7,
        S_FIN   = 4'd8,
        S_ERR   = 4'd9
    } dma_state_e;

    // Which shadow register drives D_IN of the generator.
    typedef enum logic [1:0] {
        D_ZERO = 2'd0,
        D_CTRL = 2'd1,
        D_ADDR = 2'd2,
        D_WC   = 2'd3
    } dsel_e;

    typedef struct packed {
        am2940_instr_e instr;
        dsel_e         dsel;
        logic          aci;
        logic          wci;
        logic          noea;
        logic          mem_req;
        logic          busy;
        logic          complete;
        logic          error;
    } dma_out_t;

    function automatic dma_out_t decode_state(input dma_state_e s);
        dma_out_t o;
        o.instr    = I_RD_CR;
        o.dsel     = D_ZERO;
        o.aci      = 1'b1;
        o.wci      = 1'b1;
        o.noea     = 1'b1;
        o.mem_req  = 1'b0;
        o.busy     = 1'b0;
        o.complete = 1'b0;
        o.error    = 1'b0;
        case (s)
            S_LD_CR: begin
                o.instr = I_WR_CR;
                o.dsel  = D_CTRL;
                o.busy  = 1'b1;
            end
            S_LD_AD: begin
                o.instr = I_LD_ADDR;
                o.dsel  = D_ADDR;
                o.busy  = 1'b1;
            end
            S_LD_WC: begin
                o.instr = I_LD_WC;
                o.dsel  = D_WC;
                o.busy  = 1'b1;
            end
            S_ARM, S_CHECK: begin
                o.instr = I_EN_CNT;
                o.busy  = 1'b1;
            end
            S_REQ: begin
                o.instr   = I_EN_CNT;
                o.noea    = 1'b0;
                o.mem_req = 1'b1;
                o.busy    = 1'b1;
            end
            // Carry-ins low for exactly one cycle: one address/word count step.
            S_STEP: begin
                o.instr = I_EN_CNT;
                o.aci   = 1'b0;
                o.wci   = 1'b0;
                o.noea  = 1'b0;
                o.busy  = 1'b1;
            end
            S_FIN: begin
                o.complete = 1'b1;
                o.busy     = 1'b1;
            end
            S_ERR: begin
                o.error = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/am2940_dma_sequencer_dma_timeout_cnt.sv
// Counts REQ cycles without an acknowledge; expire flags the last allowed cycle.
module dma_timeout_cnt #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tmo <= '0;
        end else if (clr) begin
            tmo <= '0;
        end else if (en) begin
            tmo <= tmo + TW'(1);
        end
    end

    assign expire = (tmo == LAST);

endmodule

// File: rtl/am2940_dma_sequencer.sv
// Upstream sequencer for am2940_top: programs control/address/word count, then runs
// req/ack memory beats with a counter step after each, until DONE, timeout or abort.
module am2940_dma_sequencer
    import am2940_dma_sequencer_pkg::*;
#(
    parameter int DW      = 4,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4,
    parameter int BW      = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] cfg_ctrl,
    input  logic [DW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wc,
    input  logic          mem_ack,
    input  logic          done,
    output logic [2:0]    i_code,
    output logic [DW-1:0] d_out,
    output logic          aci,
    output logic          wci,
    output logic          noea,
    output logic          mem_req,
    output logic          busy,
    output logic          complete,
    output logic          error,
    output logic [BW-1:0] beat_cnt
);

    dma_state_e    state;
    dma_state_e    state_n;
    dma_out_t      outs;
    logic          tmo_expire;
    logic          take_start;
    logic [DW-1:0] ctrl_sh;
    logic [DW-1:0] addr_sh;
    logic [DW-1:0] wc_sh;

    dma_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_tmo (
        .clk    (clk),
        .res    (res),
        .clr    (state != S_REQ),
        .en     ((state == S_REQ) && !mem_ack),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // abort outranks every other transition; done only matters once counters settled.
    always_comb begin
        state_n = state;
        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERR: if (start) state_n = S_LD_CR;
                S_LD_CR:       state_n = S_LD_AD;
                S_LD_AD:       state_n = S_LD_WC;
                S_LD_WC:       state_n = S_ARM;
                S_ARM, S_CHECK: state_n = done ? S_FIN : S_REQ;
                S_REQ: begin
                    if (mem_ack) begin
                        state_n = S_STEP;
                    end else if (tmo_expire) begin
                        state_n = S_ERR;
                    end
                end
                S_STEP:        state_n = S_CHECK;
                S_FIN:         state_n = S_IDLE;
                default:       state_n = S_IDLE;
            endcase
        end
    end

    assign take_start = ((state == S_IDLE) || (state == S_ERR)) && (state_n == S_LD_CR);

    // Shadow copies hold the programming values for the whole run.
    always_ff @(posedge clk) begin
        if (take_start) begin
            ctrl_sh <= cfg_ctrl;
            addr_sh <= cfg_addr;
            wc_sh   <= cfg_wc;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            beat_cnt <= '0;
        end else if (take_start) begin
            beat_cnt <= '0;
        end else if (state == S_STEP) begin
            beat_cnt <= beat_cnt + BW'(1);
        end
    end

    assign outs     = decode_state(state);
    assign i_code   = outs.instr;
    assign aci      = outs.aci;
    assign wci      = outs.wci;
    assign noea     = outs.noea;
    assign mem_req  = outs.mem_req;
    assign busy     = outs.busy;
    assign complete = outs.complete;
    assign error    = outs.error;

    always_comb begin
        d_out = '0;
        case (outs.dsel)
            D_CTRL:  d_out = ctrl_sh;
            D_ADDR:  d_out = addr_sh;
            D_WC:    d_out = wc_sh;
            default: d_out = '0;
        endcase
    end

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Scoreboard bench for am2940_dma_sequencer with a word-count generator model.
module tb_am2940_dma_sequencer;

    localparam int DW      = 4;
    localparam int TIMEOUT = 15;
    localparam int TW      = 4;
    localparam int BW      = 8;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_ctrl = '0;
    logic [DW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_wc = '0;
    logic          mem_ack;
    logic          done;
    logic [2:0]    i_code;
    logic [DW-1:0] d_out;
    logic          aci, wci, noea, mem_req, busy, complete, error;
    logic [BW-1:0] beat_cnt;

    am2940_dma_sequencer #(
        .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW), .BW(BW)
    ) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .abort    (abort),
        .cfg_ctrl (cfg_ctrl),
        .cfg_addr (cfg_addr),
        .cfg_wc   (cfg_wc),
        .mem_ack  (mem_ack),
        .done     (done),
        .i_code   (i_code),
        .d_out    (d_out),
        .aci      (aci),
        .wci      (wci),
        .noea     (noea),
        .mem_req  (mem_req),
        .busy     (busy),
        .complete (complete),
        .error    (error),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 complete, 1 timeout error, 2 abort
        int cyc;
        int beats;
        int ctrl;
        int addr;
        int wc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   delays[16];
    int   beat_idx = 0;
    int   req_wait = 0;
    int   gen_wc = 0;
    logic ack_drv = 1'b0;
    logic noise = 1'b0;
    logic [21:0] rst_exp = {3'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    // Acks outside REQ are random noise the sequencer must ignore.
    assign mem_ack = ack_drv | (noise & ~mem_req);
    assign done    = (gen_wc == 0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory: acknowledges beat n after delays[n] extra REQ cycles.
    always @(posedge clk) begin
        #1;
        noise = 1'($urandom_range(0, 1));
        if (res || !mem_req) begin
            ack_drv  = 1'b0;
            req_wait = 0;
        end else begin
            if (beat_idx < 16 && req_wait >= delays[beat_idx]) begin
                ack_drv = 1'b1;
                beat_idx++;
            end else begin
                ack_drv = 1'b0;
            end
            req_wait++;
        end
    end

    // Word-count side of the generator: loaded by LD_WC, decremented per step.
    always @(negedge clk) begin
        if (res) gen_wc = 0;
        else if (i_code == 3'd6) gen_wc = int'(d_out);
        else if (i_code == 3'd7 && !wci) gen_wc = gen_wc - 1;
    end

    task automatic expect_event(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
            return;
        end
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_beat_cnt", int'(beat_cnt), e.beats);
    endtask

    logic prev_busy = 1'b0, prev_error = 1'b0, prev_complete = 1'b0;
    int   phase = 0;

    always @(negedge clk) begin
        if (res) begin
            prev_busy = 1'b0; prev_error = 1'b0; prev_complete = 1'b0; phase = 0;
        end else begin
            if (busy && !prev_busy) phase = 1;
            if (phase > 0) begin
                if (q.size() == 0) begin
                    chk("setup_without_expectation", 1, 0);
                    phase = 0;
                end else begin
                    case (phase)
                        1: begin
                            chk("ld_cr_icode", int'(i_code), 0);
                            chk("ld_cr_data", int'(d_out), q[0].ctrl);
                            chk("start_clears_error", int'(error), 0);
                            chk("start_clears_beats", int'(beat_cnt), 0);
                        end
                        2: begin
                            chk("ld_ad_icode", int'(i_code), 5);
                            chk("ld_ad_data", int'(d_out), q[0].addr);
                        end
                        3: begin
                            chk("ld_wc_icode", int'(i_code), 6);
                            chk("ld_wc_data", int'(d_out), q[0].wc);
                        end
                        default: chk("arm_icode", int'(i_code), 7);
                    endcase
                    phase = (phase == 4) ? 0 : phase + 1;
                end
            end
            if (complete) begin
                expect_event(0);
            end else if (error && !prev_error) begin
                expect_event(1);
                chk("err_mem_req", int'(mem_req), 0);
                chk("err_noea", int'(noea), 1);
            end else if (!busy && prev_busy && !prev_complete && !error) begin
                expect_event(2);
            end
            prev_busy = busy; prev_error = error; prev_complete = complete;
        end
    end

    // Reference: 4 setup cycles, (delay+3) per acked beat, TIMEOUT REQ cycles then ERR,
    // one FIN cycle; abort lands in IDLE the cycle after it is seen.
    task automatic run_xfer(input int c, input int a, input int w, input int abort_beat,
                            input bit busy_start);
        exp_t e;
        int   k;
        bit   ended, saw_req, aborted;
        e.kind = 0; e.ctrl = c; e.addr = a; e.wc = w; e.beats = w; k = 4;
        for (int i = 0; i < w; i++) begin
            if (abort_beat == i) begin
                e.kind = 2; e.beats = i; break;
            end
            if (delays[i] >= TIMEOUT) begin
                e.kind = 1; e.beats = i; k = k + TIMEOUT + 1; break;
            end
            k = k + delays[i] + 3;
        end
        if (e.kind == 0) k = k + 1;
        beat_idx = 0;
        cfg_ctrl = 4'(c); cfg_addr = 4'(a); cfg_wc = 4'(w);
        start = 1'b1;
        e.cyc = cyc + k;
        q.push_back(e);
        ended = 0; saw_req = 0; aborted = 0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #2;
            start = 1'b0; abort = 1'b0;
            if (q.size() == 0) begin
                ended = 1; break;
            end
            cfg_ctrl = 4'($urandom); cfg_addr = 4'($urandom); cfg_wc = 4'($urandom);
            if (mem_req) saw_req = 1;
            if (abort_beat >= 0 && !aborted && mem_req && !ack_drv && beat_idx == abort_beat) begin
                abort = 1'b1; aborted = 1; q[0].cyc = cyc + 1;
            end else if (busy_start && mem_req) begin
                start = 1'b1;
            end
        end
        chk("xfer_terminates", int'(ended), 1);
        if (w == 0) chk("no_mem_req_when_done_in_arm", int'(saw_req), 0);
    endtask

    task automatic clear_delays(input int v);
        for (int i = 0; i < 16; i++) delays[i] = v;
    endtask

    initial begin
        exp_t e;
        bit   found;
        int   w, ab;
        clear_delays(0);
        res = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", int'({i_code, d_out, aci, wci, noea, mem_req, busy, complete, error, beat_cnt}),
            int'(rst_exp));
        res = 1'b0;
        @(posedge clk); #2;

        clear_delays(0);
        run_xfer(0, 3, 4, -1, 0);

        clear_delays(0); delays[1] = 5;
        run_xfer(2, 7, 4, -1, 0);

        clear_delays(0); delays[0] = 40;
        run_xfer(1, 2, 3, -1, 0);
        chk("err_level_held", int'(error), 1);

        clear_delays(0); delays[0] = TIMEOUT - 1;
        run_xfer(3, 1, 2, -1, 0);

        clear_delays(0);
        run_xfer(1, 4, 0, -1, 1);

        clear_delays(2);
        run_xfer(2, 5, 6, 3, 1);

        // Asynchronous reset while the counters are stepping.
        clear_delays(0);
        beat_idx = 0;
        cfg_ctrl = 4'd5; cfg_addr = 4'd9; cfg_wc = 4'd6;
        e.kind = 0; e.cyc = 0; e.beats = 6; e.ctrl = 5; e.addr = 9; e.wc = 6;
        q.push_back(e);
        start = 1'b1;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            start = 1'b0;
            cfg_ctrl = 4'($urandom); cfg_addr = 4'($urandom); cfg_wc = 4'($urandom);
            if (i_code == 3'd7 && !aci) begin
                found = 1; break;
            end
        end
        chk("reached_step", int'(found), 1);
        res = 1'b1;
        #1;
        chk("async_reset_outputs", int'({i_code, d_out, aci, wci, noea, mem_req, busy, complete, error, beat_cnt}),
            int'(rst_exp));
        q.delete();
        @(posedge clk); #2;
        res = 1'b0;
        @(posedge clk); #2;

        for (int r = 0; r < 12; r++) begin
            w = $urandom_range(0, 7);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 9) == 0) delays[i] = $urandom_range(TIMEOUT - 1, TIMEOUT + 3);
                else delays[i] = $urandom_range(0, 4);
            end
            ab = -1;
            if (w > 0 && $urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, w - 1);
                for (int i = 0; i < ab; i++) if (delays[i] >= TIMEOUT) ab = -1;
                if (ab >= 0 && delays[ab] == 0) delays[ab] = 1;
            end
            run_xfer($urandom_range(0, 15), $urandom_range(0, 15), w, ab, 1'($urandom_range(0, 1)));
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
